// File: rtl/time_pkg.sv
// Shared BCD digit types, the packed time-of-day struct, the wrap limits of each
// field, and the 24h -> 12h hour mapping used by the TIME_OF_DAY_COUNTER_12H_EN build.
package time_pkg;

  typedef logic [3:0] bcd4_t;
  typedef logic [2:0] bcd3_t;
  typedef logic [1:0] bcd2_t;

  typedef struct packed {
    bcd2_t hour_tens;
    bcd4_t hour_units;
    bcd3_t min_tens;
    bcd4_t min_units;
    bcd3_t sec_tens;
    bcd4_t sec_units;
  } hms_t;

  // Largest value of each field as BCD tens/units (59, 59, 23).
  localparam int SEC_MAX_TENS   = 5;
  localparam int SEC_MAX_UNITS  = 9;
  localparam int MIN_MAX_TENS   = 5;
  localparam int MIN_MAX_UNITS  = 9;
  localparam int HOUR_MAX_TENS  = 2;
  localparam int HOUR_MAX_UNITS = 3;

  // Returns {pm, tens[1:0], units[3:0]} for a 24-hour BCD hour.
  function automatic logic [6:0] to_12h(input bcd2_t tens, input bcd4_t units);
    logic [4:0] hr;
    logic [4:0] h12;
    logic       t12;
    logic [4:0] u12;
    hr = 5'(tens) * 5'd10 + 5'(units);
    if (hr == 5'd0)      h12 = 5'd12;
    else if (hr > 5'd12) h12 = hr - 5'd12;
    else                 h12 = hr;
    t12 = (h12 >= 5'd10);
    u12 = t12 ? (h12 - 5'd10) : h12;
    return {(hr >= 5'd12), {1'b0, t12}, u12[3:0]};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps to 00 after TENS_MAX:UNITS_AT_TENS_MAX.
// carry_out is combinational and flags the increment that causes the wrap.
module bcd_mod_counter
  import time_pkg::*;
#(
  parameter int TENS_W            = 3,
  parameter int TENS_MAX          = 5,
  parameter int UNITS_AT_TENS_MAX = 9
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              inc_in,
  input  logic              clr_in,
  output logic [TENS_W-1:0] tens_out,
  output bcd4_t             units_out,
  output logic              carry_out
);

  localparam logic [TENS_W-1:0] TMAX = TENS_W'(TENS_MAX);
  localparam bcd4_t             UMAX = 4'(UNITS_AT_TENS_MAX);

  logic [TENS_W-1:0] tens_q, tens_d;
  bcd4_t             units_q, units_d;
  logic              at_max;

  assign at_max    = (tens_q == TMAX) && (units_q == UMAX);
  assign carry_out = inc_in && !clr_in && at_max;

  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    if (clr_in) begin
      tens_d  = '0;
      units_d = '0;
    end else if (inc_in) begin
      if (at_max) begin
        tens_d  = '0;
        units_d = '0;
      end else if (units_q == 4'd9) begin
        tens_d  = tens_q + 1'b1;
        units_d = '0;
      end else begin
        units_d = units_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      tens_q  <= '0;
      units_q <= '0;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign tens_out  = tens_q;
  assign units_out = units_q;

endmodule

// File: rtl/time_of_day_counter.sv
// HH:MM:SS BCD time-of-day counter fed by a tick strobe, with set pulses and a
// minute-rollover strobe. Define TIME_OF_DAY_COUNTER_12H_EN for 12-hour outputs.
module time_of_day_counter
  import time_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       set_min_in,
  input  logic       set_hour_in,
  input  logic       clear_sec_in,
  output logic [1:0] hour_tens_out,
  output logic [3:0] hour_units_out,
  output logic [2:0] min_tens_out,
  output logic [3:0] min_units_out,
  output logic [2:0] sec_tens_out,
  output logic [3:0] sec_units_out,
  output logic       pm_out,
  output logic       minute_strobe_out
);

  localparam int                TICK_W = $clog2(TICK_DIV) + 1;
  localparam logic [TICK_W-1:0] RELOAD = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] presc_q, presc_d;
  logic              strobe_q;
  logic              sec_adv, sec_carry, min_inc, min_wrap, hour_carry, hour_inc;
  logic              hour_wrap_unused;
  hms_t              time_w;

  assign sec_adv = tick_in && (presc_q == '0);

  always_comb begin
    presc_d = presc_q;
    if (clear_sec_in)     presc_d = RELOAD;
    else if (sec_adv)     presc_d = RELOAD;
    else if (tick_in)     presc_d = presc_q - 1'b1;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      presc_q  <= RELOAD;
      strobe_q <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      strobe_q <= sec_carry;
    end
  end

  bcd_mod_counter #(.TENS_W(3), .TENS_MAX(SEC_MAX_TENS), .UNITS_AT_TENS_MAX(SEC_MAX_UNITS)) u_sec (
    .clk_in(clk_in), .reset(reset), .inc_in(sec_adv), .clr_in(clear_sec_in),
    .tens_out(time_w.sec_tens), .units_out(time_w.sec_units), .carry_out(sec_carry)
  );

  // A coincident carry and set advance minutes once; only a pure carry wrap ripples into hours.
  assign min_inc    = sec_carry || set_min_in;
  assign hour_carry = min_wrap && !set_min_in;
  assign hour_inc   = hour_carry || set_hour_in;

  bcd_mod_counter #(.TENS_W(3), .TENS_MAX(MIN_MAX_TENS), .UNITS_AT_TENS_MAX(MIN_MAX_UNITS)) u_min (
    .clk_in(clk_in), .reset(reset), .inc_in(min_inc), .clr_in(1'b0),
    .tens_out(time_w.min_tens), .units_out(time_w.min_units), .carry_out(min_wrap)
  );

  bcd_mod_counter #(.TENS_W(2), .TENS_MAX(HOUR_MAX_TENS), .UNITS_AT_TENS_MAX(HOUR_MAX_UNITS)) u_hour (
    .clk_in(clk_in), .reset(reset), .inc_in(hour_inc), .clr_in(1'b0),
    .tens_out(time_w.hour_tens), .units_out(time_w.hour_units), .carry_out(hour_wrap_unused)
  );

  assign min_tens_out      = time_w.min_tens;
  assign min_units_out     = time_w.min_units;
  assign sec_tens_out      = time_w.sec_tens;
  assign sec_units_out     = time_w.sec_units;
  assign minute_strobe_out = strobe_q;

`ifdef TIME_OF_DAY_COUNTER_12H_EN
  logic [6:0] h12_w;
  assign h12_w          = to_12h(time_w.hour_tens, time_w.hour_units);
  assign pm_out         = h12_w[6];
  assign hour_tens_out  = h12_w[5:4];
  assign hour_units_out = h12_w[3:0];
`else
  assign pm_out         = 1'b0;
  assign hour_tens_out  = time_w.hour_tens;
  assign hour_units_out = time_w.hour_units;
`endif

endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed bench for time_of_day_counter: dut_a runs TICK_DIV=1, dut_b TICK_DIV=4.
module tb_time_of_day_counter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick_a = 0, set_min_a = 0, set_hour_a = 0, clr_a = 0;
  logic tick_b = 0, set_min_b = 0, set_hour_b = 0, clr_b = 0;

  logic [1:0] ht_a, ht_b;
  logic [3:0] hu_a, hu_b, mu_a, mu_b, su_a, su_b;
  logic [2:0] mt_a, mt_b, st_a, st_b;
  logic       pm_a, pm_b, strobe_a, strobe_b;

  logic [19:0] hms_a, hms_b;
  assign hms_a = {ht_a, hu_a, mt_a, mu_a, st_a, su_a};
  assign hms_b = {ht_b, hu_b, mt_b, mu_b, st_b, su_b};

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  time_of_day_counter #(.TICK_DIV(1)) dut_a (
    .clk_in(clk), .reset(reset), .tick_in(tick_a), .set_min_in(set_min_a),
    .set_hour_in(set_hour_a), .clear_sec_in(clr_a),
    .hour_tens_out(ht_a), .hour_units_out(hu_a), .min_tens_out(mt_a), .min_units_out(mu_a),
    .sec_tens_out(st_a), .sec_units_out(su_a), .pm_out(pm_a), .minute_strobe_out(strobe_a)
  );

  time_of_day_counter #(.TICK_DIV(4)) dut_b (
    .clk_in(clk), .reset(reset), .tick_in(tick_b), .set_min_in(set_min_b),
    .set_hour_in(set_hour_b), .clear_sec_in(clr_b),
    .hour_tens_out(ht_b), .hour_units_out(hu_b), .min_tens_out(mt_b), .min_units_out(mu_b),
    .sec_tens_out(st_b), .sec_units_out(su_b), .pm_out(pm_b), .minute_strobe_out(strobe_b)
  );

  // Expected BCD packing of a raw hh:mm:ss, same layout as hms_a/hms_b.
  function automatic logic [19:0] mk(input int h, input int m, input int s);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  // One-cycle pulse on dut_a inputs; returns at the sampling negedge after the edge.
  task automatic pulse_a(input logic t, input logic sm, input logic sh, input logic cs);
    @(negedge clk);
    tick_a = t; set_min_a = sm; set_hour_a = sh; clr_a = cs;
    @(negedge clk);
    tick_a = 0; set_min_a = 0; set_hour_a = 0; clr_a = 0;
  endtask

  task automatic pulse_b(input logic t, input logic cs);
    @(negedge clk);
    tick_b = t; clr_b = cs;
    @(negedge clk);
    tick_b = 0; clr_b = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (hms_a !== mk(0, 0, 0)) begin n_err++; $display("FAIL reset_time_a: got %h want %h", hms_a, mk(0, 0, 0)); end
    n_cmp++;
    if (hms_b !== mk(0, 0, 0)) begin n_err++; $display("FAIL reset_time_b: got %h want %h", hms_b, mk(0, 0, 0)); end
    n_cmp++;
    if ({strobe_a, pm_a, strobe_b, pm_b} !== 4'b0) begin
      n_err++; $display("FAIL reset_flags: got %b want 0000", {strobe_a, pm_a, strobe_b, pm_b});
    end
  endtask

  task automatic test_rollover();
    int strobe_cnt = 0;
    int strobe_at = -1;
    do_reset();
    @(negedge clk);
    tick_a = 1;
    for (int k = 1; k <= 62; k++) begin
      @(negedge clk);
      if (k == 61) tick_a = 0;
      if (strobe_a) begin strobe_cnt++; strobe_at = k; end
    end
    n_cmp++;
    if (hms_a !== mk(0, 1, 1)) begin n_err++; $display("FAIL rollover_time: got %h want %h", hms_a, mk(0, 1, 1)); end
    n_cmp++;
    if (strobe_cnt !== 1 || strobe_at !== 60) begin
      n_err++; $display("FAIL rollover_strobe: got count %0d at %0d want count 1 at 60", strobe_cnt, strobe_at);
    end
  endtask

  task automatic test_prescaler();
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      pulse_b(1, 0);
      if (k == 3 || k == 4 || k == 7 || k == 8) begin
        n_cmp++;
        if (hms_b !== mk(0, 0, (k + 4) / 4 - 1 + (k >= 4 ? 0 : 0))) begin
          n_err++; $display("FAIL prescale_tick%0d: got %h want %h", k, hms_b, mk(0, 0, (k + 4) / 4 - 1));
        end
      end
    end
    // Two ticks into the next second, clear restarts the prescaler from TICK_DIV-1.
    pulse_b(1, 0);
    pulse_b(1, 0);
    pulse_b(0, 1);
    for (int k = 1; k <= 3; k++) pulse_b(1, 0);
    n_cmp++;
    if (hms_b !== mk(0, 0, 0)) begin n_err++; $display("FAIL prescale_after_clear3: got %h want %h", hms_b, mk(0, 0, 0)); end
    pulse_b(1, 0);
    n_cmp++;
    if (hms_b !== mk(0, 0, 1)) begin n_err++; $display("FAIL prescale_after_clear4: got %h want %h", hms_b, mk(0, 0, 1)); end
  endtask

  task automatic test_midnight();
    logic [19:0] exp_pre;
    do_reset();
    for (int k = 0; k < 23; k++) pulse_a(0, 0, 1, 0);
    for (int k = 0; k < 59; k++) pulse_a(0, 1, 0, 0);
    for (int k = 0; k < 59; k++) pulse_a(1, 0, 0, 0);
`ifdef TIME_OF_DAY_COUNTER_12H_EN
    exp_pre = mk(11, 59, 59);
`else
    exp_pre = mk(23, 59, 59);
`endif
    n_cmp++;
    if (hms_a !== exp_pre) begin n_err++; $display("FAIL midnight_preload: got %h want %h", hms_a, exp_pre); end
    pulse_a(1, 0, 0, 0);
    n_cmp++;
    if (hms_a !== mk(0, 0, 0) && hms_a !== mk(12, 0, 0)) begin
      n_err++; $display("FAIL midnight_wrap: got %h want 00:00:00", hms_a);
    end
`ifndef TIME_OF_DAY_COUNTER_12H_EN
    n_cmp++;
    if (hms_a !== mk(0, 0, 0)) begin n_err++; $display("FAIL midnight_wrap24: got %h want %h", hms_a, mk(0, 0, 0)); end
`endif
    n_cmp++;
    if (strobe_a !== 1'b1) begin n_err++; $display("FAIL midnight_strobe: got %b want 1", strobe_a); end
    @(negedge clk);
    n_cmp++;
    if (strobe_a !== 1'b0) begin n_err++; $display("FAIL midnight_strobe_len: got %b want 0", strobe_a); end
  endtask

  task automatic test_set_and_carry();
    do_reset();
    pulse_a(0, 0, 1, 0);
    for (int k = 0; k < 59; k++) pulse_a(0, 1, 0, 0);
    pulse_a(0, 1, 0, 0);
    n_cmp++;
    if (hms_a !== mk(1, 0, 0) || strobe_a !== 1'b0) begin
      n_err++; $display("FAIL set_min_wrap: got %h strobe %b want %h strobe 0", hms_a, strobe_a, mk(1, 0, 0));
    end
    for (int k = 0; k < 59; k++) pulse_a(1, 0, 0, 0);
    pulse_a(1, 1, 0, 0);
    n_cmp++;
    if (hms_a !== mk(1, 1, 0) || strobe_a !== 1'b1) begin
      n_err++; $display("FAIL tick_set_coincide: got %h strobe %b want %h strobe 1", hms_a, strobe_a, mk(1, 1, 0));
    end
    // Minute 59 wrapped by a coincident carry and set must not ripple to hours.
    for (int k = 0; k < 58; k++) pulse_a(0, 1, 0, 0);
    for (int k = 0; k < 59; k++) pulse_a(1, 0, 0, 0);
    pulse_a(1, 1, 0, 0);
    n_cmp++;
    if (hms_a !== mk(1, 0, 0) || strobe_a !== 1'b1) begin
      n_err++; $display("FAIL coincide_no_ripple: got %h strobe %b want %h strobe 1", hms_a, strobe_a, mk(1, 0, 0));
    end
    for (int k = 0; k < 59; k++) pulse_a(0, 1, 0, 0);
    for (int k = 0; k < 60; k++) pulse_a(1, 0, 0, 0);
    n_cmp++;
    if (hms_a !== mk(2, 0, 0)) begin n_err++; $display("FAIL carry_ripple: got %h want %h", hms_a, mk(2, 0, 0)); end
  endtask

  task automatic test_clear_sec();
    do_reset();
    pulse_a(0, 1, 0, 0);
    for (int k = 0; k < 59; k++) pulse_a(1, 0, 0, 0);
    pulse_a(1, 0, 0, 1);
    n_cmp++;
    if (hms_a !== mk(0, 1, 0) || strobe_a !== 1'b0) begin
      n_err++; $display("FAIL clear_overrides: got %h strobe %b want %h strobe 0", hms_a, strobe_a, mk(0, 1, 0));
    end
    @(negedge clk);
    n_cmp++;
    if (strobe_a !== 1'b0) begin n_err++; $display("FAIL clear_no_strobe: got %b want 0", strobe_a); end
  endtask

  task automatic test_reset_mid();
    pulse_a(0, 0, 1, 0);
    for (int k = 0; k < 5; k++) pulse_a(1, 0, 0, 0);
    @(negedge clk);
    #2 reset = 1;
    #1;
    n_cmp++;
    if (hms_a !== mk(0, 0, 0) || strobe_a !== 1'b0) begin
      n_err++; $display("FAIL reset_async: got %h want %h", hms_a, mk(0, 0, 0));
    end
    @(negedge clk);
    reset = 0;
    pulse_a(1, 0, 0, 0);
    n_cmp++;
    if (hms_a !== mk(0, 0, 1)) begin n_err++; $display("FAIL resume_after_reset: got %h want %h", hms_a, mk(0, 0, 1)); end
  endtask

  task automatic test_hour_format();
    logic [6:0] exp0, exp12, exp13;
`ifdef TIME_OF_DAY_COUNTER_12H_EN
    exp0 = 7'b0_01_0010; exp12 = 7'b1_01_0010; exp13 = 7'b1_00_0001;
`else
    exp0 = 7'b0_00_0000; exp12 = 7'b0_01_0010; exp13 = 7'b0_01_0011;
`endif
    do_reset();
    n_cmp++;
    if ({pm_a, ht_a, hu_a} !== exp0) begin n_err++; $display("FAIL hour_fmt_00: got %b want %b", {pm_a, ht_a, hu_a}, exp0); end
    for (int k = 0; k < 12; k++) pulse_a(0, 0, 1, 0);
    n_cmp++;
    if ({pm_a, ht_a, hu_a} !== exp12) begin n_err++; $display("FAIL hour_fmt_12: got %b want %b", {pm_a, ht_a, hu_a}, exp12); end
    pulse_a(0, 0, 1, 0);
    n_cmp++;
    if ({pm_a, ht_a, hu_a} !== exp13) begin n_err++; $display("FAIL hour_fmt_13: got %b want %b", {pm_a, ht_a, hu_a}, exp13); end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_rollover();
    test_prescaler();
    test_midnight();
    test_set_and_carry();
    test_clear_sec();
    test_reset_mid();
    test_hour_format();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/time_of_day_counter.md
Name: time_of_day_counter

Overview:
- Timekeeping stage directly downstream of the strobe divider; consumes its one-cycle tick strobe on tick_in.
- Maintains seconds, minutes and hours as BCD digits and accepts user set pulses.
- Emits a minute-rollover strobe for the downstream alarm comparator and display mux.

Parameters:
- TICK_DIV, 1: number of tick_in strobes per second; legal range >=1. A value of 1 makes every tick one second.
- TICK_W, derived as $clog2(TICK_DIV)+1: width of the internal prescale counter.

Ports:
- clk_in  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick_in  in  1  single-cycle strobe from upstream divider
- set_min_in  in  1  single-cycle pulse (already debounced and synchronized); increment minutes
- set_hour_in  in  1  single-cycle pulse; increment hours
- clear_sec_in  in  1  single-cycle pulse; zero seconds and the prescaler
- hour_tens_out  out  2  BCD hour tens
- hour_units_out  out  4  BCD hour units
- min_tens_out  out  3  BCD minute tens
- min_units_out  out  4  BCD minute units
- sec_tens_out  out  3  BCD second tens
- sec_units_out  out  4  BCD second units
- pm_out  out  1  PM flag, valid only in 12-hour build
- minute_strobe_out  out  1  one-cycle pulse on seconds wrap 59->00

Behaviour:
- Reset (asynchronous): all digits 0 (00:00:00), prescaler = TICK_DIV-1, minute_strobe_out = 0, pm_out = 0.
- Prescaler:
  - Decrements on each tick_in.
  - When it is 0 and tick_in is high, it reloads TICK_DIV-1 and raises a one-second advance (sec_adv) in the same cycle.
  - tick_in while the prescaler is nonzero only decrements.
- Seconds:
  - Advance on sec_adv: units 0..9, tens 0..5. All digit updates are registered, so outputs change one clock after the causing event.
  - 59->00 produces a minute carry and drives minute_strobe_out high for exactly the next cycle only.
- Minutes:
  - 00..59. Advance on minute carry OR set_min_in, by exactly one even if both occur in the same cycle.
  - 59->00 from the carry path produces an hour carry.
  - 59->00 caused by set_min_in (alone or coinciding with the carry) produces no hour carry; setting never ripples.
- Hours:
  - 00..23. Advance on hour carry OR set_hour_in, by exactly one if both occur. 23->00 wraps silently.
- clear_sec_in:
  - Forces seconds to 00 and the prescaler to TICK_DIV-1 next cycle.
  - Overrides a coincident sec_adv: no minute carry, no strobe.
  - Does not affect minutes or hours.
- Set pulses do not assert minute_strobe_out.
- Multi-cycle set inputs are out of contract; each high cycle counts as one increment.
- Digits never hold non-BCD values; there are no illegal states reachable after reset.
- Reset asserted mid-operation returns everything to 00:00:00 immediately. Counting resumes on the first tick_in after deassertion.

Optional Feature:
- Macro TIME_OF_DAY_COUNTER_12H_EN.
- When defined:
  - The internal count stays 24-hour.
  - Hour outputs are mapped combinationally to 12-hour form: 00->12 AM, 01..11 AM, 12->12 PM, 13..23 -> 01..11 PM.
  - pm_out = 1 for internal hours 12..23.
- When undefined: hour outputs are raw 24-hour BCD and pm_out is tied 0.
- Counting, carries and strobes are identical in both builds.

Decomposition:
- Package time_pkg holds:
  - typedefs bcd4_t (logic [3:0]), bcd3_t, bcd2_t;
  - a packed struct hms_t carrying the six digits;
  - constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, expressed as BCD tens/units.
- Sub-module bcd_mod_counter, a two-digit BCD counter:
  - parameters TENS_MAX and UNITS_AT_TENS_MAX;
  - inputs inc, clr; output carry on wrap.
- It is instantiated three times. Hour carry suppression for set pulses lives in the parent.

Test Plan:
- TICK_DIV=1, reset, then 61 ticks -> 00:01:01. minute_strobe_out is high for exactly 1 cycle, one clock after the 60th tick.
- TICK_DIV=4, 7 ticks -> seconds=01. The 8th tick -> seconds=02. No change on non-reload ticks.
- Preload to 23:59:59 via set pulses and ticks, then 1 tick -> 00:00:00, with minute_strobe_out pulsed once.
- Minutes at 59, set_min_in -> minutes 00, hours unchanged. Seconds at 59 with tick and set_min_in in the same cycle -> minutes +1 only, strobe asserted.
- Seconds at 59 with clear_sec_in and tick coincident -> seconds 00, minutes unchanged, no strobe. Reset asserted mid-count -> immediate 00:00:00.
- 12H build: hours 00 -> outputs 12, pm_out=0; hours 13 -> outputs 01, pm_out=1; hours 12 -> 12, pm_out=1.
